mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative signed/unsigned multiply-divide unit for the multicycle datapath; successor to the fixed 32-cycle MULT/DIV counter loop.
//  Generalised to WIDTH bits, adds unsigned ops, start/busy/done handshake, divide-by-zero flag and cancel (exception flush).
//  Driven by the control FSM; results feed the HI/LO registers when done pulses.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH bits each; iteration count = WIDTH (counter width $clog2(WIDTH+1), local)
// PORTS
//  clock     in   1      single clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  op        in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  a         in   WIDTH  multiplicand / dividend, sampled with start
//  b         in   WIDTH  multiplier / divisor, sampled with start
//  cancel    in   1      abort current operation (exception flush)
//  busy      out  1      high in CALC and FIX
//  done      out  1      one-cycle pulse: hi/lo valid (or div_zero)
//  div_zero  out  1      pulses with done when a DIV/DIVU had b==0
//  hi        out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo        out  WIDTH  MULT: product[W-1:0]; DIV: quotient
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-operation): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
//  States: IDLE, CALC, FIX, DONE.
//   IDLE: start=1 & cancel=0 -> latch op, |a|,|b| (abs only for signed ops), result signs; counter=0.
//     DIV/DIVU with b==0 -> DONE with div_zero=1; else -> CALC.
//   CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle; counter++; counter==WIDTH-1 -> FIX.
//   FIX: apply sign correction; register hi/lo; -> DONE.
//   DONE: done=1 for exactly this cycle; -> IDLE.
//  Latency: start sampled at edge t -> done high in the cycle after edge t+WIDTH+1 (WIDTH+2 cycles).
//    Divide-by-zero: done and div_zero high in the cycle after edge t.
//  hi/lo change only on the edge entering DONE from FIX; they hold their values otherwise. On div_zero, hi/lo are unchanged.
//  start while busy or in DONE: ignored, no queueing. Operands may change after the start edge.
//  cancel=1 in CALC/FIX: next state IDLE, no done, hi/lo unchanged. Same cycle as start in IDLE: cancel wins, start is dropped.
//    In DONE: done still pulses (result already committed).
//  Arithmetic, signed mult: full 2W-bit two's-complement product; unsigned: 2W-bit magnitude product.
//  Arithmetic, signed div: quotient truncates toward zero; remainder takes the sign of the dividend.
//    -2^(W-1) / -1 -> lo=-2^(W-1), hi=0 (wraps, no flag).
//  Internal accumulator is 2W+1 bits; no overflow output.
// TESTING (WIDTH=32)
//  MULT a=7, b=-3 -> done at start+34 cycles, hi=FFFFFFFF, lo=FFFFFFEB; busy high for cycles 1..33.
//  MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; then MULT of the same operands -> hi=0, lo=1.
//  DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  DIVU a=7, b=0 -> done+div_zero on the next cycle, hi/lo keep their prior values; busy never rises.
//  Cancel: start MULT, assert cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//    A new DIVU 100/7 then gives lo=14, hi=2.
//  Drop reset to 0 mid-CALC -> all outputs 0 immediately. Start pulses during busy are ignored (single done, first operands' result).

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply-divide unit with a start/busy/done handshake.
// It takes one shift-add or restoring shift-subtract step per cycle, then applies sign correction.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] b_mag;
  logic             is_div;
  logic             neg_quot;
  logic             neg_rem;
  logic             dz_flag;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH:0] mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [2*WIDTH:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes and one iteration step for each operation.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_abs     = a_neg ? (~a + 1'b1) : a;
    b_abs     = b_neg ? (~b + 1'b1) : b;

    add_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next = {1'b0, add_sum, acc[WIDTH-1:1]};

    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    if (rem_sh >= {1'b0, b_mag})
      div_next = {rem_sh - {1'b0, b_mag}, acc[WIDTH-2:0], 1'b1};
    else
      div_next = {rem_sh, acc[WIDTH-2:0], 1'b0};

    prod     = acc[2*WIDTH-1:0];
    prod_fix = neg_quot ? (~prod + 1'b1) : prod;
    quot_fix = neg_quot ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      b_mag    <= '0;
      is_div   <= 1'b0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      dz_flag  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          dz_flag <= 1'b0;
          if (start && !cancel) begin
            count    <= '0;
            acc      <= {{(WIDTH+1){1'b0}}, a_abs};
            b_mag    <= b_abs;
            is_div   <= op[1];
            neg_quot <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            if (op[1] && (b == '0)) begin
              dz_flag <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc   <= is_div ? div_next : mul_next;
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            state <= DONE;
          end
        end
        DONE: begin
          dz_flag <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == CALC) || (state == FIX);
  assign done     = (state == DONE);
  assign div_zero = (state == DONE) && dz_flag;

endmodule
